mac_tap_sequencer: RTL and testbench

- Sequences one MAC_Pipeline instance through a KernelSize-tap dot product for one convolution output pixel.
- Per tap: fetches weight and input operands from the weight/input buffers, issues them to the MAC with the running partial sum on O_Data, waits for the MAC result, and captures it as the new partial sum.
- Sits between the engine's top-level pixel scheduler (start/done handshake) and the MAC datapath. Also drives the operand-buffer read addresses.

---
 rtl/mac_tap_sequencer.sv | 107 ++++++++++
 tb/tb_mac_tap_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_tap_sequencer.sv
// mac_tap_sequencer: walks one MAC pipeline through a KernelSize-tap dot product per output pixel
module mac_tap_sequencer #(
    parameter int DataInWidth   = 8,
    parameter int DataOutWidth  = 16,
    parameter int AddrWidth     = 8,
    parameter int KernelSize    = 9,
    parameter int TimeoutCycles = 15
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [DataOutWidth-1:0] bias,
    input  logic [AddrWidth-1:0]    w_base,
    input  logic [AddrWidth-1:0]    i_base,
    input  logic                    stall,
    output logic                    busy,
    output logic                    rd_en,
    output logic [AddrWidth-1:0]    w_addr,
    output logic [AddrWidth-1:0]    i_addr,
    input  logic [DataInWidth-1:0]  w_rdata,
    input  logic [DataInWidth-1:0]  i_rdata,
    output logic                    NOPIn,
    output logic [DataInWidth-1:0]  W_Data,
    output logic [DataInWidth-1:0]  I_Data,
    output logic [DataOutWidth-1:0] O_Data,
    input  logic [DataOutWidth-1:0] DataOut,
    input  logic                    NOPOut,
    output logic [DataOutWidth-1:0] result,
    output logic                    done,
    output logic                    error
);
    localparam int TW = $clog2(KernelSize + 1);
    localparam int CW = $clog2(TimeoutCycles + 1);
    typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, DONE} state_t;
    state_t state, state_nx;
    logic [TW-1:0] tap;
    logic [CW-1:0] to_cnt;
    logic [AddrWidth-1:0] w_base_r, i_base_r;
    logic [DataOutWidth-1:0] acc, o_hold;
    logic [DataInWidth-1:0] w_hold, i_hold;
    logic last_tap, timed_out;
    assign last_tap  = tap == TW'(KernelSize - 1);
    assign timed_out = to_cnt == CW'(TimeoutCycles - 1);
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = start ? FETCH : IDLE;
            FETCH:   state_nx = stall ? FETCH : ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT:    state_nx = !NOPOut ? (last_tap ? DONE : FETCH) : (timed_out ? DONE : WAIT);
            default: state_nx = IDLE;
        endcase
        busy   = state != IDLE;
        rd_en  = state == FETCH && !stall;
        NOPIn  = state != ISSUE;
        done   = state == DONE;
        w_addr = w_base_r + AddrWidth'(tap);
        i_addr = i_base_r + AddrWidth'(tap);
        // Operands are forwarded straight from the buffers during ISSUE and held afterwards
        W_Data = NOPIn ? w_hold : w_rdata;
        I_Data = NOPIn ? i_hold : i_rdata;
        O_Data = NOPIn ? o_hold : acc;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            tap      <= '0;
            to_cnt   <= '0;
            w_base_r <= '0;
            i_base_r <= '0;
            acc      <= '0;
            o_hold   <= '0;
            w_hold   <= '0;
            i_hold   <= '0;
            result   <= '0;
            error    <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                acc      <= bias;
                w_base_r <= w_base;
                i_base_r <= i_base;
                tap      <= '0;
                error    <= 1'b0;
            end
            if (state == ISSUE) begin
                w_hold <= w_rdata;
                i_hold <= i_rdata;
                o_hold <= acc;
                to_cnt <= '0;
            end
            // A result arriving on the timeout cycle still counts as a capture
            if (state == WAIT) begin
                if (!NOPOut) begin
                    acc <= DataOut;
                    if (!last_tap)
                        tap <= tap + 1'b1;
                end else if (timed_out)
                    error <= 1'b1;
                else
                    to_cnt <= to_cnt + 1'b1;
            end
            if (state == DONE)
                result <= acc;
        end
    end
endmodule

// File: tb/tb_mac_tap_sequencer.sv
// tb_mac_tap_sequencer: scoreboard bench driving a 3-tap and a 9-tap sequencer with buffer and 2-cycle MAC models
module tb_mac_tap_sequencer;
    logic clk = 0;
    logic reset = 1;
    logic [1:0] start = '0;
    logic [15:0] bias = '0;
    logic [7:0] w_base = '0;
    logic [7:0] i_base = '0;
    logic stall = 0;
    logic mac_dead = 0;
    logic [1:0] busy, rd_en, nop_in, done, error;
    logic [1:0][7:0] w_addr, i_addr, w_data, i_data;
    logic [1:0][15:0] o_data, result;
    logic [7:0] wmem[256];
    logic [7:0] imem[256];
    logic [15:0] oq[$];
    logic [15:0] last_result[2];
    int passed = 0;
    int total = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : u
        logic [7:0] w_rdata, i_rdata;
        logic v1 = 0, v2 = 0;
        logic [15:0] d1 = '0, d2 = '0;
        mac_tap_sequencer #(.KernelSize(g == 0 ? 3 : 9)) dut (
            .clk(clk), .reset(reset), .start(start[g]), .bias(bias), .w_base(w_base), .i_base(i_base),
            .stall(stall), .busy(busy[g]), .rd_en(rd_en[g]), .w_addr(w_addr[g]), .i_addr(i_addr[g]),
            .w_rdata(w_rdata), .i_rdata(i_rdata), .NOPIn(nop_in[g]), .W_Data(w_data[g]),
            .I_Data(i_data[g]), .O_Data(o_data[g]), .DataOut(d2), .NOPOut(!v2),
            .result(result[g]), .done(done[g]), .error(error[g])
        );
        always @(posedge clk) begin
            w_rdata <= rd_en[g] ? wmem[w_addr[g]] : 8'($urandom);
            i_rdata <= rd_en[g] ? imem[i_addr[g]] : 8'($urandom);
            v1 <= !nop_in[g] && !mac_dead;
            d1 <= o_data[g] + 16'(w_data[g]) * 16'(i_data[g]);
            v2 <= v1;
            d2 <= d1;
        end
    end

    task automatic test_reset;
        #12;
        for (int g = 0; g < 2; g++) begin
            total++;
            if ({busy[g], rd_en[g], nop_in[g], done[g], error[g], w_addr[g], i_addr[g], w_data[g], i_data[g], o_data[g], result[g]} !== {5'b00100, 64'd0})
                $display("FAIL reset_outputs dut%0d: got busy=%b rd_en=%b nop_in=%b done=%b error=%b waddr=%0d iaddr=%0d w=%0d i=%0d o=%0d result=%0d, want nop_in=1 rest 0",
                         g, busy[g], rd_en[g], nop_in[g], done[g], error[g], w_addr[g], i_addr[g], w_data[g], i_data[g], o_data[g], result[g]);
            else passed++;
        end
        @(posedge clk);
        #1 reset = 0;
        last_result = '{default: 16'd0};
    endtask

    task automatic run_pixel(input int g, input logic [15:0] b, input logic [7:0] wb, input logic [7:0] ib,
                             input bit do_stall, input bit dead, input bit mid_start, input string name);
        int k, n, exp_done, fetches, issues, ti, dc;
        logic [15:0] acc, last_o;
        k = g == 0 ? 3 : 9;
        n = dead ? 1 : k;
        exp_done = dead ? 17 : 4 * k + (do_stall ? 4 : 0);
        fetches = 0;
        issues = 0;
        ti = -1;
        dc = -1;
        last_o = '0;
        acc = b;
        for (int t = 0; t < n; t++) begin
            oq.push_back(acc);
            acc += 16'(wmem[8'(wb + t)]) * 16'(imem[8'(ib + t)]);
        end
        if (dead) acc = b;
        @(posedge clk);
        #1;
        start[g] = 1;
        bias = b;
        w_base = wb;
        i_base = ib;
        for (int c = 0; c < 100 && dc < 0; c++) begin
            @(posedge clk);
            #1;
            start[g] = mid_start && c == 4;
            if (mid_start && c == 4) begin
                bias = b + 16'd77;
                w_base = wb + 8'd9;
            end
            stall = do_stall && ti >= 0 && c >= ti + 3 && c < ti + 7;
            @(negedge clk);
            if (c == 0) begin
                total++;
                if (error[g] !== 1'b0) $display("FAIL %s error_clear: got %b want 0", name, error[g]);
                else passed++;
            end
            if (stall) begin
                total++;
                if (rd_en[g] !== 1'b0) $display("FAIL %s stall_rd_en cycle %0d: got %b want 0", name, c, rd_en[g]);
                else passed++;
            end
            if (rd_en[g]) begin
                total++;
                if (w_addr[g] !== 8'(wb + fetches) || i_addr[g] !== 8'(ib + fetches))
                    $display("FAIL %s addr tap %0d: got w=%0d i=%0d want w=%0d i=%0d", name, fetches,
                             w_addr[g], i_addr[g], 8'(wb + fetches), 8'(ib + fetches));
                else passed++;
                fetches++;
            end
            if (!nop_in[g]) begin
                total++;
                if (oq.size() == 0) $display("FAIL %s issue_extra cycle %0d: got issue with O=%0d want none", name, c, o_data[g]);
                else begin
                    last_o = oq.pop_front();
                    if (o_data[g] !== last_o) $display("FAIL %s issue_odata tap %0d: got %0d want %0d", name, issues, o_data[g], last_o);
                    else passed++;
                end
                if (ti < 0) ti = c;
                issues++;
            end else if (issues > 0) begin
                total++;
                if (o_data[g] !== last_o) $display("FAIL %s odata_hold cycle %0d: got %0d want %0d", name, c, o_data[g], last_o);
                else passed++;
            end
            if (done[g]) begin
                dc = c;
                total++;
                if (result[g] !== last_result[g]) $display("FAIL %s result_at_done: got %0d want %0d", name, result[g], last_result[g]);
                else passed++;
            end
        end
        total++;
        if (dc !== exp_done) $display("FAIL %s done_cycle: got %0d want %0d (-1 = none in budget)", name, dc, exp_done);
        else passed++;
        @(negedge clk);
        total++;
        if (result[g] !== acc) $display("FAIL %s result: got %0d want %0d", name, result[g], acc);
        else passed++;
        total++;
        if ({done[g], busy[g], error[g]} !== {2'b00, dead})
            $display("FAIL %s end_flags: got done=%b busy=%b error=%b want 0 0 %b", name, done[g], busy[g], error[g], dead);
        else passed++;
        total++;
        if (issues !== n || fetches !== n) $display("FAIL %s tap_counts: got issues=%0d fetches=%0d want %0d", name, issues, fetches, n);
        else passed++;
        total++;
        if (oq.size() != 0) $display("FAIL %s leftover_issues: got %0d want 0", name, oq.size());
        else passed++;
        oq.delete();
        last_result[g] = acc;
        stall = 0;
        start = '0;
    endtask

    task automatic test_basic_k3;
        wmem[30] = 10; wmem[31] = 5; wmem[32] = 5;
        imem[16] = 20; imem[17] = 20; imem[18] = 10;
        run_pixel(0, 16'd30, 8'd30, 8'd16, 0, 0, 0, "basic_k3");
        total++;
        if (result[0] !== 16'd380) $display("FAIL basic_k3 result_const: got %0d want 380", result[0]);
        else passed++;
    endtask

    task automatic test_k9_wrap_sum;
        for (int t = 0; t < 9; t++) begin
            wmem[100 + t] = 8'd255;
            imem[200 + t] = 8'd255;
        end
        run_pixel(1, 16'd0, 8'd100, 8'd200, 0, 0, 0, "k9_max");
        total++;
        if (result[1] !== 16'd60937) $display("FAIL k9_max result_const: got %0d want 60937", result[1]);
        else passed++;
    endtask

    task automatic test_addr_wrap;
        run_pixel(1, 16'd7, 8'd250, 8'd120, 0, 0, 0, "addr_wrap");
    endtask

    task automatic test_stall;
        run_pixel(0, 16'd30, 8'd30, 8'd16, 1, 0, 0, "stall");
    endtask

    task automatic test_timeout;
        mac_dead = 1;
        run_pixel(0, 16'd500, 8'd30, 8'd16, 0, 1, 0, "timeout");
        mac_dead = 0;
        run_pixel(0, 16'd30, 8'd30, 8'd16, 0, 0, 0, "after_timeout");
    endtask

    task automatic test_mid_start;
        run_pixel(1, 16'd1000, 8'd60, 8'd70, 0, 0, 1, "mid_start");
        repeat (3) @(negedge clk);
        total++;
        if (busy[1] !== 1'b0) $display("FAIL mid_start idle_after: got busy=%b want 0", busy[1]);
        else passed++;
    endtask

    task automatic test_reset_mid;
        @(posedge clk);
        #1;
        start[1] = 1;
        bias = 16'h1234;
        w_base = 8'd3;
        i_base = 8'd4;
        @(posedge clk);
        #1 start[1] = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1;
        #1;
        for (int g = 0; g < 2; g++) begin
            total++;
            if ({busy[g], rd_en[g], nop_in[g], done[g], error[g], w_addr[g], i_addr[g], w_data[g], i_data[g], o_data[g], result[g]} !== {5'b00100, 64'd0})
                $display("FAIL reset_mid dut%0d: got busy=%b rd_en=%b nop_in=%b done=%b error=%b waddr=%0d iaddr=%0d w=%0d i=%0d o=%0d result=%0d, want nop_in=1 rest 0",
                         g, busy[g], rd_en[g], nop_in[g], done[g], error[g], w_addr[g], i_addr[g], w_data[g], i_data[g], o_data[g], result[g]);
            else passed++;
        end
        @(posedge clk);
        #1 reset = 0;
        last_result = '{default: 16'd0};
        repeat (4) @(posedge clk);
        run_pixel(1, 16'd9, 8'd250, 8'd120, 0, 0, 0, "after_reset");
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            wmem[i] = 8'($urandom);
            imem[i] = 8'($urandom);
        end
        test_reset;
        test_basic_k3;
        test_k9_wrap_sum;
        test_addr_wrap;
        test_stall;
        test_timeout;
        test_mid_start;
        test_reset_mid;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
